// File: rtl/jt900h_regbank.sv
// JT900H register file: BANKS x 4 general longs, PTRS pointer longs, two read ports, sized write, auto-step.
// Optional byte-stream dump engine enabled by defining JT900H_REGBANK_DUMP_EN.
module jt900h_regbank #(
    parameter int  BANKS = 4,
    parameter int  PTRS  = 4,
    localparam int RFPW  = ($clog2(BANKS) > 1) ? $clog2(BANKS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    output logic [RFPW-1:0] rfp,
    input  logic            inc_rfp,
    input  logic            dec_rfp,
    input  logic [7:0]      rd0_sel,
    input  logic [7:0]      rd1_sel,
    output logic [31:0]     rd0_data,
    output logic [31:0]     rd1_data,
    input  logic            wr_en,
    input  logic [1:0]      wr_size,
    input  logic [7:0]      wr_sel,
    input  logic [31:0]     wr_data,
    input  logic [7:0]      stp_sel,
    input  logic [1:0]      stp_size,
    input  logic            stp_inc,
    input  logic            stp_dec,
    output logic [31:0]     stp_addr,
    input  logic            dmp_start,
    output logic            dmp_busy,
    output logic            dmp_valid,
    input  logic            dmp_ready,
    output logic [7:0]      dmp_addr,
    output logic [7:0]      dmp_data
);

    // Flat long layout: bank longs first (bank*4 + long), then pointer longs.
    localparam int NL  = 4 * BANKS + PTRS;
    localparam int LIW = $clog2(NL);
    localparam int NB  = 4 * NL;
    localparam int DIW = LIW + 2;

    logic [31:0]     regs_reg  [NL];
    logic [31:0]     regs_next [NL];
    logic [RFPW-1:0] rfp_reg;

    // Returns {valid, flat long index} for a select's long-aligned part.
    function automatic logic [LIW:0] decode(input logic [5:0] s, input logic [RFPW-1:0] p);
        logic [3:0]      code;
        logic [RFPW-1:0] pm1;
        logic            ok;
        int              lw;
        int              li;
        code = s[5:2];
        lw   = int'(s[1:0]);
        pm1  = p - RFPW'(1);
        ok   = 1'b0;
        li   = 0;
        if (int'(code) < BANKS) begin
            ok = 1'b1;
            li = int'(code) * 4 + lw;
        end else if (code == 4'hE) begin
            ok = 1'b1;
            li = int'(p) * 4 + lw;
        end else if (code == 4'hD) begin
            ok = 1'b1;
            li = int'(pm1) * 4 + lw;
        end else if (code == 4'hF && lw < PTRS) begin
            ok = 1'b1;
            li = 4 * BANKS + lw;
        end
        return {ok, LIW'(li)};
    endfunction

    logic [LIW:0] rd0_loc, rd1_loc, wr_loc, stp_loc;

    assign rd0_loc = decode(rd0_sel[7:2], rfp_reg);
    assign rd1_loc = decode(rd1_sel[7:2], rfp_reg);
    assign wr_loc  = decode(wr_sel[7:2],  rfp_reg);
    assign stp_loc = decode(stp_sel[7:2], rfp_reg);

    assign rfp      = rfp_reg;
    assign rd0_data = rd0_loc[LIW] ? regs_reg[rd0_loc[LIW-1:0]] : 32'd0;
    assign rd1_data = rd1_loc[LIW] ? regs_reg[rd1_loc[LIW-1:0]] : 32'd0;

    logic unused_sel;
    assign unused_sel = ^{rd0_sel[1:0], rd1_sel[1:0], stp_sel[1:0]};

    // Step unit
    logic [31:0] stp_val, stp_step, stp_res;
    logic        stp_we;

    always_comb begin
        case (stp_size)
            2'd1:    stp_step = 32'd2;
            2'd2:    stp_step = 32'd4;
            default: stp_step = 32'd1;
        endcase
    end

    assign stp_val  = stp_loc[LIW] ? regs_reg[stp_loc[LIW-1:0]] : 32'd0;
    assign stp_we   = stp_loc[LIW] && (stp_inc ^ stp_dec);
    assign stp_res  = stp_inc ? stp_val + stp_step : stp_val - stp_step;
    assign stp_addr = (stp_dec && !stp_inc) ? stp_val - stp_step : stp_val;

    // Write port: replicate data so each enabled lane sees its LSB-aligned byte.
    logic [3:0]  wr_mask;
    logic [31:0] wr_lanes;
    logic        wr_we;

    always_comb begin
        wr_mask  = 4'b0000;
        wr_lanes = wr_data;
        case (wr_size)
            2'd0: begin
                wr_mask  = 4'b0001 << wr_sel[1:0];
                wr_lanes = {4{wr_data[7:0]}};
            end
            2'd1: begin
                wr_mask  = wr_sel[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{wr_data[15:0]}};
            end
            2'd2:    wr_mask = 4'b1111;
            default: wr_mask = 4'b0000;
        endcase
    end

    assign wr_we = wr_en && wr_loc[LIW];

    genvar gi;
    generate
        for (gi = 0; gi < NL; gi++) begin : g_long
            logic [31:0] long_next;
            logic        wr_hit, stp_hit;

            assign wr_hit  = wr_we  && (wr_loc[LIW-1:0]  == LIW'(gi));
            assign stp_hit = stp_we && (stp_loc[LIW-1:0] == LIW'(gi));

            // The write port owns its lanes; untouched lanes may still take the step result.
            always_comb begin
                long_next = regs_reg[gi];
                for (int l = 0; l < 4; l++) begin
                    if (wr_hit && wr_mask[l])
                        long_next[8*l +: 8] = wr_lanes[8*l +: 8];
                    else if (stp_hit)
                        long_next[8*l +: 8] = stp_res[8*l +: 8];
                end
            end

            assign regs_next[gi] = long_next;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NL; i++) regs_reg[i] <= 32'd0;
            rfp_reg <= '0;
        end else if (cen) begin
            for (int i = 0; i < NL; i++) regs_reg[i] <= regs_next[i];
            if (inc_rfp && !dec_rfp)
                rfp_reg <= rfp_reg + RFPW'(1);
            else if (dec_rfp && !inc_rfp)
                rfp_reg <= rfp_reg - RFPW'(1);
        end
    end

`ifdef JT900H_REGBANK_DUMP_EN
    typedef enum logic {DMP_IDLE, DMP_RUN} dmp_state_t;

    dmp_state_t     state_reg, state_next;
    logic [DIW-1:0] idx_reg, idx_next;
    logic [31:0]    dmp_long;
    logic           running;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= DMP_IDLE;
            idx_reg   <= '0;
        end else if (cen) begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            DMP_IDLE: begin
                if (dmp_start) begin
                    state_next = DMP_RUN;
                    idx_next   = '0;
                end
            end
            DMP_RUN: begin
                if (dmp_ready) begin
                    if (idx_reg == DIW'(NB - 1)) begin
                        state_next = DMP_IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + DIW'(1);
                    end
                end
            end
        endcase
    end

    // Byte index maps straight onto the flat layout, so pointer bytes follow bank bytes.
    assign running   = (state_reg == DMP_RUN);
    assign dmp_long  = regs_reg[idx_reg[DIW-1:2]];
    assign dmp_busy  = running;
    assign dmp_valid = running;
    assign dmp_data  = running ? dmp_long[{idx_reg[1:0], 3'b000} +: 8] : 8'd0;
    assign dmp_addr  = !running ? 8'd0 :
                       (idx_reg < DIW'(16 * BANKS)) ? 8'(idx_reg) :
                       (8'(idx_reg - DIW'(16 * BANKS)) | 8'h80);
`else
    logic unused_dmp;
    assign unused_dmp = ^{dmp_start, dmp_ready};
    assign dmp_busy   = 1'b0;
    assign dmp_valid  = 1'b0;
    assign dmp_addr   = 8'd0;
    assign dmp_data   = 8'd0;
`endif

endmodule

// File: tb/tb_jt900h_regbank.sv
// Directed, table-driven bench for jt900h_regbank (BANKS=4, PTRS=4); dump checks follow JT900H_REGBANK_DUMP_EN.
module tb_jt900h_regbank;
    localparam int BANKS = 4;
    localparam int PTRS  = 4;
    localparam int NDB   = 16 * BANKS + 4 * PTRS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b1;
    logic [1:0]  rfp;
    logic        inc_rfp = 1'b0, dec_rfp = 1'b0;
    logic [7:0]  rd0_sel = 8'h00, rd1_sel = 8'h00;
    logic [31:0] rd0_data, rd1_data;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_size = 2'd0;
    logic [7:0]  wr_sel = 8'h00;
    logic [31:0] wr_data = 32'd0;
    logic [7:0]  stp_sel = 8'h00;
    logic [1:0]  stp_size = 2'd0;
    logic        stp_inc = 1'b0, stp_dec = 1'b0;
    logic [31:0] stp_addr;
    logic        dmp_start = 1'b0, dmp_busy, dmp_valid, dmp_ready = 1'b0;
    logic [7:0]  dmp_addr, dmp_data;

    always #5 clk = ~clk;

    jt900h_regbank #(.BANKS(BANKS), .PTRS(PTRS)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .rfp(rfp),
        .inc_rfp(inc_rfp), .dec_rfp(dec_rfp),
        .rd0_sel(rd0_sel), .rd1_sel(rd1_sel), .rd0_data(rd0_data), .rd1_data(rd1_data),
        .wr_en(wr_en), .wr_size(wr_size), .wr_sel(wr_sel), .wr_data(wr_data),
        .stp_sel(stp_sel), .stp_size(stp_size), .stp_inc(stp_inc), .stp_dec(stp_dec),
        .stp_addr(stp_addr),
        .dmp_start(dmp_start), .dmp_busy(dmp_busy), .dmp_valid(dmp_valid),
        .dmp_ready(dmp_ready), .dmp_addr(dmp_addr), .dmp_data(dmp_data)
    );

    typedef struct {
        bit          wr;
        logic [1:0]  size;
        logic [7:0]  sel;
        logic [31:0] data;   // write data, or expected read value
        string       name;
    } vec_t;

    vec_t        vt[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cnt;
    logic [7:0]  exp_b [NDB];

    function automatic vec_t mk(bit wr, logic [1:0] sz, logic [7:0] sel, logic [31:0] d, string n);
        vec_t v;
        v.wr = wr; v.size = sz; v.sel = sel; v.data = d; v.name = n;
        return v;
    endfunction

    function automatic logic [7:0] exp_addr(int i);
        return (i < 16 * BANKS) ? 8'(i) : 8'(128 + i - 16 * BANKS);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] sel, input logic [31:0] exp);
        rd0_sel = sel;
        rd1_sel = sel;
        #1;
        chk({name, ".rd0"}, rd0_data, exp);
        chk({name, ".rd1"}, rd1_data, exp);
    endtask

    task automatic wr_op(input logic [7:0] sel, input logic [1:0] sz, input logic [31:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_size = sz; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        // Vectors assume rfp = 0 and a freshly reset file.
        vt.push_back(mk(0, 2'd0, 8'h00, 32'h00000000, "rst_b0l0"));
        vt.push_back(mk(0, 2'd0, 8'h2C, 32'h00000000, "rst_b2l3"));
        vt.push_back(mk(0, 2'd0, 8'hF0, 32'h00000000, "rst_xix"));
        vt.push_back(mk(0, 2'd0, 8'hFC, 32'h00000000, "rst_xsp"));
        vt.push_back(mk(1, 2'd2, 8'h20, 32'h11223344, "wr_long"));
        vt.push_back(mk(0, 2'd0, 8'h20, 32'h11223344, "rd_long"));
        vt.push_back(mk(0, 2'd0, 8'h22, 32'h11223344, "rd_unaligned"));
        vt.push_back(mk(1, 2'd1, 8'h21, 32'h00007777, "wr_word_lo"));
        vt.push_back(mk(0, 2'd0, 8'h20, 32'h11227777, "rd_word_lo"));
        vt.push_back(mk(1, 2'd1, 8'h16, 32'h0000BEEF, "wr_word_hi"));
        vt.push_back(mk(0, 2'd0, 8'h14, 32'hBEEF0000, "rd_word_hi"));
        vt.push_back(mk(1, 2'd0, 8'h17, 32'h0000005A, "wr_byte3"));
        vt.push_back(mk(0, 2'd0, 8'h14, 32'h5AEF0000, "rd_byte3"));
        vt.push_back(mk(1, 2'd0, 8'h50, 32'h000000FF, "wr_badbank"));
        vt.push_back(mk(0, 2'd0, 8'h50, 32'h00000000, "rd_badbank"));
        vt.push_back(mk(0, 2'd0, 8'h00, 32'h00000000, "rd_b0_clean"));
        vt.push_back(mk(1, 2'd3, 8'h30, 32'hFFFFFFFF, "wr_size3"));
        vt.push_back(mk(0, 2'd0, 8'h30, 32'h00000000, "rd_size3"));
        vt.push_back(mk(1, 2'd2, 8'hE8, 32'hCAFEF00D, "wr_cur"));
        vt.push_back(mk(0, 2'd0, 8'h08, 32'hCAFEF00D, "rd_cur"));
        vt.push_back(mk(1, 2'd2, 8'hD0, 32'h01020304, "wr_prev"));
        vt.push_back(mk(0, 2'd0, 8'h30, 32'h01020304, "rd_prev_b3"));
        vt.push_back(mk(0, 2'd0, 8'hD0, 32'h01020304, "rd_prev_d"));
        vt.push_back(mk(1, 2'd2, 8'hF8, 32'h0000ABCD, "wr_xiz"));
        vt.push_back(mk(0, 2'd0, 8'hF8, 32'h0000ABCD, "rd_xiz"));

        // Reset state, checked while reset is held
        #1;
        chk("rst_rfp", 32'(rfp), 32'd0);
        chk("rst_valid", 32'(dmp_valid), 32'd0);
        chk("rst_busy", 32'(dmp_busy), 32'd0);
        chk("rst_dmp_addr", 32'(dmp_addr), 32'd0);
        chk("rst_dmp_data", 32'(dmp_data), 32'd0);
        chk("rst_stp_addr", stp_addr, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        foreach (vt[i]) begin
            if (vt[i].wr) wr_op(vt[i].sel, vt[i].size, vt[i].data);
            else          rd_chk(vt[i].name, vt[i].sel, vt[i].data);
        end

        // Bank pointer
        dec_rfp = 1'b1; tick(); dec_rfp = 1'b0;
        chk("rfp_dec_wrap", 32'(rfp), 32'd3);
        wr_op(8'hE5, 2'd0, 32'h000000AA);
        rd_chk("rd_e5_b3", 8'h34, 32'h0000AA00);
        inc_rfp = 1'b1; dec_rfp = 1'b1; tick(); inc_rfp = 1'b0; dec_rfp = 1'b0;
        chk("rfp_both", 32'(rfp), 32'd3);
        inc_rfp = 1'b1; wr_op(8'hE8, 2'd2, 32'h12345678); inc_rfp = 1'b0;
        chk("rfp_inc_wrap", 32'(rfp), 32'd0);
        rd_chk("rd_old_rfp", 8'h38, 32'h12345678);
        cen = 1'b0; dec_rfp = 1'b1; wr_op(8'h04, 2'd2, 32'hDEADBEEF); dec_rfp = 1'b0; cen = 1'b1;
        chk("rfp_cen0", 32'(rfp), 32'd0);
        rd_chk("rd_cen0", 8'h04, 32'h00000000);

        // Step unit on XIY
        stp_sel = 8'hF4; stp_size = 2'd2; stp_dec = 1'b1; #1;
        chk("stp_predec_addr", stp_addr, 32'hFFFFFFFC);
        tick(); stp_dec = 1'b0;
        rd_chk("stp_predec_reg", 8'hF4, 32'hFFFFFFFC);
        stp_size = 2'd1; stp_inc = 1'b1; #1;
        chk("stp_postinc_addr", stp_addr, 32'hFFFFFFFC);
        tick(); stp_inc = 1'b0;
        rd_chk("stp_postinc_reg", 8'hF4, 32'hFFFFFFFE);
        stp_inc = 1'b1; stp_dec = 1'b1; #1;
        chk("stp_both_addr", stp_addr, 32'hFFFFFFFE);
        tick(); stp_inc = 1'b0; stp_dec = 1'b0;
        rd_chk("stp_both_reg", 8'hF4, 32'hFFFFFFFE);
        stp_size = 2'd2; stp_inc = 1'b1; tick(); stp_inc = 1'b0;
        rd_chk("stp_inc_wrap", 8'hF4, 32'h00000002);

        // Write port vs step unit in the same cycle
        wr_op(8'hF0, 2'd2, 32'h000000FF);
        stp_sel = 8'hF0; stp_size = 2'd0; stp_inc = 1'b1;
        wr_op(8'hF0, 2'd0, 32'h00000055);
        stp_inc = 1'b0;
        rd_chk("collide", 8'hF0, 32'h00000155);

        // Reset clears everything written so far
        rst_n = 1'b0; #1;
        chk("rst2_rfp", 32'(rfp), 32'd0);
        rd_chk("rst2_xix", 8'hF0, 32'h00000000);
        rd_chk("rst2_b2", 8'h20, 32'h00000000);
        tick(); rst_n = 1'b1; tick();

`ifdef JT900H_REGBANK_DUMP_EN
        for (int i = 0; i < NDB; i++) exp_b[i] = 8'h00;
        wr_op(8'h20, 2'd2, 32'h11223344);
        exp_b[32] = 8'h44; exp_b[33] = 8'h33; exp_b[34] = 8'h22; exp_b[35] = 8'h11;
        wr_op(8'hFC, 2'd2, 32'hA1B2C3D4);
        exp_b[76] = 8'hD4; exp_b[77] = 8'hC3; exp_b[78] = 8'hB2; exp_b[79] = 8'hA1;
        exp_b[12] = 8'h99;   // written live while the dump is on byte 3

        dmp_ready = 1'b1; dmp_start = 1'b1; tick(); dmp_start = 1'b0;
        for (int i = 0; i < NDB; i++) begin
            chk($sformatf("dmp%0d_valid", i), 32'(dmp_valid), 32'd1);
            chk($sformatf("dmp%0d_addr", i), 32'(dmp_addr), 32'(exp_addr(i)));
            chk($sformatf("dmp%0d_data", i), 32'(dmp_data), 32'(exp_b[i]));
            if (i == 3) begin
                wr_en = 1'b1; wr_sel = 8'h0C; wr_size = 2'd0; wr_data = 32'h00000099;
            end
            tick();
            wr_en = 1'b0;
        end
        chk("dmp_done_busy", 32'(dmp_busy), 32'd0);
        chk("dmp_done_valid", 32'(dmp_valid), 32'd0);

        // Toggled ready, with a stray start in the middle
        dmp_start = 1'b1; tick(); dmp_start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 400 && dmp_busy; c++) begin
            dmp_ready = (c % 2) == 1;
            dmp_start = (c == 20);
            if (dmp_valid && dmp_ready) begin
                chk($sformatf("tgl%0d_addr", cnt), 32'(dmp_addr), 32'(exp_addr(cnt)));
                cnt++;
            end
            tick();
        end
        dmp_start = 1'b0; dmp_ready = 1'b1;
        chk("tgl_done_busy", 32'(dmp_busy), 32'd0);
        chk("tgl_count", 32'(cnt), 32'(NDB));

        // Reset in the middle of a dump
        dmp_start = 1'b1; tick(); dmp_start = 1'b0;
        repeat (10) tick();
        chk("mid_addr", 32'(dmp_addr), 32'd10);
        rst_n = 1'b0; #1;
        chk("mid_rst_valid", 32'(dmp_valid), 32'd0);
        chk("mid_rst_busy", 32'(dmp_busy), 32'd0);
        chk("mid_rst_addr", 32'(dmp_addr), 32'd0);
        chk("mid_rst_data", 32'(dmp_data), 32'd0);
        rd_chk("mid_rst_b2", 8'h20, 32'h00000000);
        tick(); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post_rst_valid%0d", k), 32'(dmp_valid), 32'd0);
        end
`else
        dmp_ready = 1'b1; dmp_start = 1'b1; tick(); dmp_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("nodump_valid%0d", k), 32'(dmp_valid), 32'd0);
            chk($sformatf("nodump_busy%0d", k), 32'(dmp_busy), 32'd0);
            tick();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
